// File: rtl/mdu_divider_if.sv
// Handshake and result bundle between the EX-stage control and the divider.
interface mdu_divider_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Pipeline side: issues requests and reads results
    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mdu_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle on magnitudes; signs are applied in a final fix-up cycle.
module mdu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    mdu_divider_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] quo_q;          // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem_q;          // one extra bit so the compare never overflows
    logic [WIDTH-1:0] divisor_mag_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dbz_q;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_out_q;

    logic             load;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // A new request is taken only when not busy; flush wins over start
    assign load = bus.start && !bus.flush && (state_q == StIdle || state_q == StDone);

    // Operand magnitudes and the shift-subtract step
    always_comb begin
        dividend_neg = bus.is_signed & bus.dividend[WIDTH-1];
        divisor_neg  = bus.is_signed & bus.divisor[WIDTH-1];
        dividend_mag = dividend_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        divisor_mag  = divisor_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

        rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, divisor_mag_q};
        rem_step  = rem_ge ? (rem_shift - {1'b0, divisor_mag_q}) : rem_shift;
        quo_step  = {quo_q[WIDTH-2:0], rem_ge};

        // Remainder follows the dividend's sign; quotient negated when signs differ
        quo_fix = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StRun;
            StRun:  if (cnt_q == '0) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: state_d = bus.start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.flush) state_d = StIdle;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration datapath and held result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            divisor_mag_q <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            dbz_out_q     <= 1'b0;
        end else begin
            if (load) begin
                cnt_q         <= CntW'(WIDTH - 1);
                quo_q         <= dividend_mag;
                rem_q         <= '0;
                divisor_mag_q <= divisor_mag;
                neg_quo_q     <= dividend_neg ^ divisor_neg;
                neg_rem_q     <= dividend_neg;
                dbz_q         <= (bus.divisor == '0);
            end else if (state_q == StRun && !bus.flush) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt_q <= cnt_q - CntW'(1);
            end
            // A zero divisor leaves the dividend in rem, so only the quotient is forced
            if (state_q == StFix && !bus.flush) begin
                quotient_q  <= dbz_q ? '1 : quo_fix;
                remainder_q <= rem_fix;
                dbz_out_q   <= dbz_q;
            end
        end
    end

    assign bus.busy        = (state_q == StRun) || (state_q == StFix);
    assign bus.done        = (state_q == StDone);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Randomized and directed check of mdu_divider against a plain-arithmetic reference.
module tb_mdu_divider;

    localparam int unsigned W   = 32;
    localparam int          Lat = W + 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mdu_divider_if #(.WIDTH(W)) bus ();

    mdu_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] held_q;
    logic [W-1:0] held_r;
    logic         held_z;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic, so -2^31 / -1 wraps to 0x80000000 naturally
    function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
    endtask

    // Cycle 0 is the negedge where start was driven; returns in the done cycle
    task automatic wait_done(input int inject_at, output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == inject_at) issue(1'b0, 32'd9, 32'd3);
            else bus.start = 1'b0;
            if (bus.busy) busy_cycles++;
        end while (!bus.done && lat < 100);
    endtask

    task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input int inject_at);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat, bc;
        ref_div(sgn, a, b, eq, er, ez);
        issue(sgn, a, b);
        wait_done(inject_at, lat, bc);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
        check_eq({tag, "_lat"}, 32'(lat), 32'(Lat));
        check_eq({tag, "_busy"}, 32'(bc), 32'(Lat - 1));
        check_eq({tag, "_q"}, bus.quotient, eq);
        check_eq({tag, "_r"}, bus.remainder, er);
        check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
        held_q = eq;
        held_r = er;
        held_z = ez;
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_hq"}, bus.quotient, held_q);
        check_eq({tag, "_hr"}, bus.remainder, held_r);
        check_eq({tag, "_hz"}, 32'(bus.div_by_zero), 32'(held_z));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic         sgn;
        int           dones;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.flush     = 1'b0;
        held_q        = '0;
        held_r        = '0;
        held_z        = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_held("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases, issued back-to-back in each done cycle
        do_op(1'b0, 32'd100, 32'd7, "divu_100_7", 0);
        do_op(1'b1, -32'sd7, 32'd2, "div_m7_2", 0);
        do_op(1'b1, 32'd7, -32'sd2, "div_7_m2", 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        do_op(1'b0, 32'h1234, 32'd0, "divu_dbz", 0);
        do_op(1'b1, -32'sd5, 32'd0, "div_dbz_neg", 0);
        do_op(1'b1, 32'd0, -32'sd3, "div_zero_dvd", 0);
        do_op(1'b0, 32'd0, 32'd3, "divu_zero_dvd", 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max", 0);
        @(negedge clk);
        check_eq("idle_done", 32'(bus.done), 32'd0);
        check_held("idle");

        // A start in mid-operation is dropped
        do_op(1'b0, 32'd100, 32'd7, "midstart", 10);
        @(negedge clk);
        check_eq("midstart_nodone", 32'(bus.done), 32'd0);
        check_eq("midstart_nobusy", 32'(bus.busy), 32'd0);

        // Flush mid-operation: no done, old results retained
        issue(1'b0, 32'd1000, 32'd10);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 15) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        check_eq("flush_busy", 32'(bus.busy), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check_eq("flush_nodone", 32'(dones), 32'd0);
        check_held("flush");

        // Flush together with start from idle
        issue(1'b0, 32'd50, 32'd5);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check_eq("flush_start_busy", 32'(bus.busy), 32'd0);

        // Reset mid-operation clears everything
        issue(1'b1, -32'sd77, 32'd4);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 20) rst_n = 1'b0;
        end
        @(negedge clk);
        held_q = '0;
        held_r = '0;
        held_z = 1'b0;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_done", 32'(bus.done), 32'd0);
        check_held("midrst");
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized operations with random idle gaps
        for (int n = 0; n < 30; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: begin
                    b = W'($urandom_range(1, 15));
                    if (sgn) b = -b;
                end
                3: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                4: a = W'($urandom_range(0, 1000));
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(sgn, a, b, $sformatf("rnd%0d", n), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
